micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Consumes the 5-bit dispatch address produced by the instruction address decoder and sequences the multi-cycle datapath: fetch, decode, execute, memory, writeback, trap.
- Drives per-cycle control strobes to the PC, IR, register file, ALU and the instruction/data memory handshakes.
- Sits between the decoder and the datapath as the control-unit state machine.

Parameters:
- UADDR_W, 5, width of the dispatch address and of alu_op.
- MUL_CYCLES, 4, number of EXEC cycles a mul (dispatch 25) occupies; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level enable; leaves IDLE when high
- dispatch_addr  input  UADDR_W  decoder output; sampled in DECODE
- imem_ready  input  1  instruction memory accepts/returns this cycle
- dmem_ready  input  1  data memory completes this cycle
- trap_clr  input  1  clears TRAP, returns to IDLE
- imem_req  output  1  instruction fetch request
- ir_load  output  1  latch instruction register
- alu_op  output  UADDR_W  registered dispatch address, valid from EXEC through WB
- dmem_req  output  1  data access request
- dmem_we  output  1  data write (store)
- reg_we  output  1  register-file write
- pc_inc  output  1  PC <= PC+4
- pc_branch  output  1  PC <= PC+imm (taken branch)
- pc_jump  output  1  PC <= rs1+imm (jalr)
- trap  output  1  illegal instruction flag
- busy  output  1  state != IDLE and state != TRAP

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, uaddr register=0, mul counter=0. All outputs 0, including alu_op.
- Outputs are Moore-decoded from state and uaddr, except ir_load, which is also qualified by imem_ready.
- Dispatch classes:
  - ALU: 1-19.
  - MUL: 25.
  - LOAD: 20.
  - STORE: 21.
  - BR_NT: 22.
  - BR_T: 23.
  - JALR: 24.
  - ILLEGAL: 0 and 26-31.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH: imem_req=1 every cycle until imem_ready=1. That cycle ir_load=1 -> DECODE. run is ignored once FETCH is entered.
- DECODE: one cycle. uaddr <= dispatch_addr. ILLEGAL -> TRAP; else -> EXEC.
- EXEC: alu_op=uaddr.
  - ALU: -> WB after 1 cycle.
  - MUL: counter loads MUL_CYCLES-1 on entry and decrements; -> WB when it reaches 0, so total EXEC cycles = MUL_CYCLES.
  - LOAD/STORE: -> MEM.
  - BR_NT: pc_inc=1 -> FETCH_OR_IDLE.
  - BR_T: pc_branch=1 -> FETCH_OR_IDLE.
  - JALR: reg_we=1, pc_jump=1 -> FETCH_OR_IDLE.
- MEM: dmem_req=1, dmem_we=(STORE), both held until dmem_ready=1.
  - LOAD -> WB.
  - STORE: pc_inc=1 in the ready cycle -> FETCH_OR_IDLE.
- WB: reg_we=1, pc_inc=1 for one cycle -> FETCH_OR_IDLE.
- FETCH_OR_IDLE: next state is FETCH if run=1, else IDLE. Sampled in the final cycle of the instruction.
- TRAP: trap=1, all other strobes 0. Held until trap_clr=1 -> IDLE. trap_clr outside TRAP is ignored.
- Exactly one of pc_inc, pc_branch, pc_jump is high per retired instruction; never more than one in any cycle.
- Latency (zero wait states): ALU 4 cycles FETCH-to-FETCH; MUL 3+MUL_CYCLES; LOAD 5; STORE 4; branch/jalr 3.
- Async reset mid-instruction aborts immediately. No partial strobes occur after rst_n falls.
- dispatch_addr changes outside DECODE have no effect.

Decomposition:
- Package useq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - dispatch constants: UA_ADD=1 … UA_SRAI=19, UA_LOAD=20, UA_STORE=21, UA_BR_NT=22, UA_BR_T=23, UA_JALR=24, UA_MUL=25.
  - class enum and a pure function mapping uaddr to class.
- One sub-module: useq_mul_counter (load/decrement/done), instanced once.

Test Plan:
- ALU path: run=1, imem_ready=1, dispatch=1 -> imem_req at cycle 1, ir_load 1, EXEC alu_op=1, WB reg_we=pc_inc=1; next FETCH at cycle 5.
- MUL stall: dispatch=25, MUL_CYCLES=4 -> EXEC held exactly 4 cycles with alu_op=25, then one WB cycle; 7 cycles FETCH-to-FETCH.
- Load with waits: dispatch=20, dmem_ready low 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles, then WB reg_we=1.
- Store: dispatch=21, dmem_ready=1 immediately -> dmem_we=1 and pc_inc=1 in the same MEM cycle, reg_we never asserted.
- Branches/jalr: dispatch 22 -> pc_inc only; 23 -> pc_branch only; 24 -> reg_we+pc_jump; each returns to FETCH 3 cycles after FETCH start.
- Illegal and reset: dispatch 0 and 27 -> trap=1 held until trap_clr, then IDLE. Also: rst_n low during MEM -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, dispatch
// addresses, and the decode from dispatch address to instruction class.
package useq_pkg;

    localparam int UA_W      = 5;
    localparam int MUL_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_MUL, CL_LOAD, CL_STORE, CL_BR_NT, CL_BR_T, CL_JALR, CL_ILLEGAL
    } uclass_e;

    localparam logic [UA_W-1:0] UA_ADD   = 5'd1;
    localparam logic [UA_W-1:0] UA_SUB   = 5'd2;
    localparam logic [UA_W-1:0] UA_SLL   = 5'd3;
    localparam logic [UA_W-1:0] UA_SLT   = 5'd4;
    localparam logic [UA_W-1:0] UA_SLTU  = 5'd5;
    localparam logic [UA_W-1:0] UA_XOR   = 5'd6;
    localparam logic [UA_W-1:0] UA_SRL   = 5'd7;
    localparam logic [UA_W-1:0] UA_SRA   = 5'd8;
    localparam logic [UA_W-1:0] UA_OR    = 5'd9;
    localparam logic [UA_W-1:0] UA_AND   = 5'd10;
    localparam logic [UA_W-1:0] UA_ADDI  = 5'd11;
    localparam logic [UA_W-1:0] UA_SLTI  = 5'd12;
    localparam logic [UA_W-1:0] UA_SLTIU = 5'd13;
    localparam logic [UA_W-1:0] UA_XORI  = 5'd14;
    localparam logic [UA_W-1:0] UA_ORI   = 5'd15;
    localparam logic [UA_W-1:0] UA_ANDI  = 5'd16;
    localparam logic [UA_W-1:0] UA_SLLI  = 5'd17;
    localparam logic [UA_W-1:0] UA_SRLI  = 5'd18;
    localparam logic [UA_W-1:0] UA_SRAI  = 5'd19;
    localparam logic [UA_W-1:0] UA_LOAD  = 5'd20;
    localparam logic [UA_W-1:0] UA_STORE = 5'd21;
    localparam logic [UA_W-1:0] UA_BR_NT = 5'd22;
    localparam logic [UA_W-1:0] UA_BR_T  = 5'd23;
    localparam logic [UA_W-1:0] UA_JALR  = 5'd24;
    localparam logic [UA_W-1:0] UA_MUL   = 5'd25;

    function automatic uclass_e ua_class(input logic [UA_W-1:0] ua);
        uclass_e cls;
        cls = CL_ILLEGAL;
        if (ua >= UA_ADD && ua <= UA_SRAI) cls = CL_ALU;
        else if (ua == UA_LOAD)            cls = CL_LOAD;
        else if (ua == UA_STORE)           cls = CL_STORE;
        else if (ua == UA_BR_NT)           cls = CL_BR_NT;
        else if (ua == UA_BR_T)            cls = CL_BR_T;
        else if (ua == UA_JALR)            cls = CL_JALR;
        else if (ua == UA_MUL)             cls = CL_MUL;
        return cls;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Decoder/memory-side inputs and datapath control strobes of the sequencer.
// slave = sequencer side, master = environment driving it.
interface micro_sequencer_if
    import useq_pkg::*;
#(
    parameter int UADDR_W = UA_W
);
    logic               run;
    logic [UADDR_W-1:0] dispatch_addr;
    logic               imem_ready;
    logic               dmem_ready;
    logic               trap_clr;
    logic               imem_req;
    logic               ir_load;
    logic [UADDR_W-1:0] alu_op;
    logic               dmem_req;
    logic               dmem_we;
    logic               reg_we;
    logic               pc_inc;
    logic               pc_branch;
    logic               pc_jump;
    logic               trap;
    logic               busy;

    modport slave (
        input  run, dispatch_addr, imem_ready, dmem_ready, trap_clr,
        output imem_req, ir_load, alu_op, dmem_req, dmem_we, reg_we,
               pc_inc, pc_branch, pc_jump, trap, busy
    );

    modport master (
        output run, dispatch_addr, imem_ready, dmem_ready, trap_clr,
        input  imem_req, ir_load, alu_op, dmem_req, dmem_we, reg_we,
               pc_inc, pc_branch, pc_jump, trap, busy
    );
endinterface

// File: rtl/useq_mul_counter.sv
// Down-counter timing the EXEC stall of a multiply; done is high at zero.
// Load has priority over decrement; it saturates at zero.
module useq_mul_counter
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)                         cnt_d = load_val;
        else if (dec && cnt_q != '0)      cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/micro_sequencer.sv
// Control FSM for the multi-cycle datapath; ALU 4 / MUL 3+MUL_CYCLES / LOAD 5 / STORE 4 / branch 3 cycles.
// Stalls in FETCH on imem_ready and in MEM on dmem_ready; strobes are Moore except ir_load and store pc_inc.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int UADDR_W    = UA_W,
    parameter int MUL_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    micro_sequencer_if.slave    bus
);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

    state_e             state_q, state_d;
    logic [UADDR_W-1:0] uaddr_q, uaddr_d;
    uclass_e            dec_cls, ex_cls;
    logic               mul_done;
    state_e             retire_nxt;

    assign dec_cls    = ua_class(bus.dispatch_addr);
    assign ex_cls     = ua_class(uaddr_q);
    assign retire_nxt = bus.run ? FETCH : IDLE;

    useq_mul_counter #(.CNT_W(MUL_CNT_W)) u_mul_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == DECODE && dec_cls == CL_MUL),
        .dec      (state_q == EXEC && ex_cls == CL_MUL),
        .load_val (MUL_LOAD),
        .done     (mul_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            uaddr_q <= '0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        uaddr_d = uaddr_q;
        case (state_q)
            IDLE:   if (bus.run) state_d = FETCH;
            FETCH:  if (bus.imem_ready) state_d = DECODE;
            DECODE: begin
                uaddr_d = bus.dispatch_addr;
                state_d = (dec_cls == CL_ILLEGAL) ? TRAP : EXEC;
            end
            EXEC: begin
                case (ex_cls)
                    CL_ALU:                      state_d = WB;
                    CL_MUL:                      if (mul_done) state_d = WB;
                    CL_LOAD, CL_STORE:           state_d = MEM;
                    CL_BR_NT, CL_BR_T, CL_JALR:  state_d = retire_nxt;
                    default:                     state_d = TRAP;
                endcase
            end
            MEM: if (bus.dmem_ready) state_d = (ex_cls == CL_LOAD) ? WB : retire_nxt;
            WB:   state_d = retire_nxt;
            TRAP: if (bus.trap_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req  = 1'b0;
        bus.ir_load   = 1'b0;
        bus.alu_op    = '0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_branch = 1'b0;
        bus.pc_jump   = 1'b0;
        bus.trap      = 1'b0;
        bus.busy      = (state_q != IDLE) && (state_q != TRAP);
        case (state_q)
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
            end
            EXEC: begin
                bus.alu_op    = uaddr_q;
                bus.pc_inc    = (ex_cls == CL_BR_NT);
                bus.pc_branch = (ex_cls == CL_BR_T);
                bus.pc_jump   = (ex_cls == CL_JALR);
                bus.reg_we    = (ex_cls == CL_JALR);
            end
            MEM: begin
                bus.alu_op   = uaddr_q;
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (ex_cls == CL_STORE);
                // Store retires in the ready cycle only, so pc_inc fires once.
                bus.pc_inc   = (ex_cls == CL_STORE) && bus.dmem_ready;
            end
            WB: begin
                bus.alu_op = uaddr_q;
                bus.reg_we = 1'b1;
                bus.pc_inc = 1'b1;
            end
            TRAP:    bus.trap = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed cycle-by-cycle bench for micro_sequencer: expected strobes queued per cycle, compared mid-cycle.
module tb_micro_sequencer;
    localparam logic [9:0] IREQ = 10'b10_0000_0000;
    localparam logic [9:0] IRL  = 10'b01_0000_0000;
    localparam logic [9:0] DREQ = 10'b00_1000_0000;
    localparam logic [9:0] DWE  = 10'b00_0100_0000;
    localparam logic [9:0] RWE  = 10'b00_0010_0000;
    localparam logic [9:0] PCI  = 10'b00_0001_0000;
    localparam logic [9:0] PCB  = 10'b00_0000_1000;
    localparam logic [9:0] PCJ  = 10'b00_0000_0100;
    localparam logic [9:0] TRP  = 10'b00_0000_0010;
    localparam logic [9:0] BSY  = 10'b00_0000_0001;
    localparam logic [9:0] FT   = IREQ | IRL | BSY;

    typedef struct packed {
        logic [9:0] flags;
        logic [4:0] alu;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_chk;
    int   n_pass;

    micro_sequencer_if #(.UADDR_W(5)) bus ();

    micro_sequencer #(.UADDR_W(5), .MUL_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [9:0] ef, input logic [4:0] ea);
        exp_t e;
        e.flags = ef;
        e.alu   = ea;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t       e;
        logic [9:0] obs;
        e   = exp_q.pop_front();
        obs = {bus.imem_req, bus.ir_load, bus.dmem_req, bus.dmem_we, bus.reg_we,
               bus.pc_inc, bus.pc_branch, bus.pc_jump, bus.trap, bus.busy};
        n_chk++;
        assert ({obs, bus.alu_op} === {e.flags, e.alu}) n_pass++;
        else $error("FAIL %s: observed flags=%b alu_op=%0d expected flags=%b alu_op=%0d",
                    tag, obs, bus.alu_op, e.flags, e.alu);
    endtask

    // One clock cycle: drive inputs just after the falling edge, check mid-low-phase.
    task automatic cyc(input string tag, input logic r, input logic [4:0] da,
                       input logic ir, input logic dr, input logic tc,
                       input logic [9:0] ef, input logic [4:0] ea);
        bus.run           = r;
        bus.dispatch_addr = da;
        bus.imem_ready    = ir;
        bus.dmem_ready    = dr;
        bus.trap_clr      = tc;
        push_exp(ef, ea);
        #2;
        check(tag);
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.run = 1'b0; bus.dispatch_addr = '0; bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0; bus.trap_clr = 1'b0;
        @(negedge clk);
        cyc("reset_hold", 1, 5'd1, 1, 1, 0, 10'b0, 5'd0);
        rst_n = 1'b1;

        // ALU op: FETCH at cycle 1, next FETCH at cycle 5
        cyc("alu_idle",   1, 5'd1, 1, 0, 0, 10'b0, 5'd0);
        cyc("alu_fetch",  1, 5'd1, 1, 0, 0, FT, 5'd0);
        cyc("alu_decode", 1, 5'd1, 1, 0, 0, BSY, 5'd0);
        cyc("alu_exec",   1, 5'd9, 1, 0, 0, BSY, 5'd1);
        cyc("alu_wb",     1, 5'd9, 1, 0, 0, RWE | PCI | BSY, 5'd1);

        // MUL: four EXEC cycles then WB
        cyc("mul_fetch",  1, 5'd25, 1, 0, 0, FT, 5'd0);
        cyc("mul_decode", 1, 5'd25, 1, 0, 0, BSY, 5'd0);
        for (int i = 0; i < 4; i++)
            cyc("mul_exec", 1, 5'd3, 1, 0, 0, BSY, 5'd25);
        cyc("mul_wb",     1, 5'd3, 1, 0, 0, RWE | PCI | BSY, 5'd25);

        // LOAD with an instruction-fetch wait and three data waits
        cyc("ld_fetch_wait", 1, 5'd20, 0, 0, 0, IREQ | BSY, 5'd0);
        cyc("ld_fetch",      1, 5'd20, 1, 0, 0, FT, 5'd0);
        cyc("ld_decode",     1, 5'd20, 1, 0, 0, BSY, 5'd0);
        cyc("ld_exec",       1, 5'd0,  1, 0, 0, BSY, 5'd20);
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 1, 5'd0, 1, 0, 0, DREQ | BSY, 5'd20);
        cyc("ld_mem_rdy",    1, 5'd0,  1, 1, 0, DREQ | BSY, 5'd20);
        cyc("ld_wb",         1, 5'd0,  1, 0, 0, RWE | PCI | BSY, 5'd20);

        // STORE with immediate data ready
        cyc("st_fetch",  1, 5'd21, 1, 0, 0, FT, 5'd0);
        cyc("st_decode", 1, 5'd21, 1, 0, 0, BSY, 5'd0);
        cyc("st_exec",   1, 5'd21, 1, 1, 0, BSY, 5'd21);
        cyc("st_mem",    1, 5'd21, 1, 1, 0, DREQ | DWE | PCI | BSY, 5'd21);

        // Branch not taken, taken, jalr (run drops on the last to go IDLE)
        cyc("brnt_fetch",  1, 5'd22, 1, 0, 0, FT, 5'd0);
        cyc("brnt_decode", 1, 5'd22, 1, 0, 0, BSY, 5'd0);
        cyc("brnt_exec",   1, 5'd22, 1, 0, 0, PCI | BSY, 5'd22);
        cyc("brt_fetch",   1, 5'd23, 1, 0, 0, FT, 5'd0);
        cyc("brt_decode",  1, 5'd23, 1, 0, 0, BSY, 5'd0);
        cyc("brt_exec",    1, 5'd23, 1, 0, 0, PCB | BSY, 5'd23);
        cyc("jalr_fetch",  1, 5'd24, 1, 0, 0, FT, 5'd0);
        cyc("jalr_decode", 1, 5'd24, 1, 0, 0, BSY, 5'd0);
        cyc("jalr_exec",   0, 5'd24, 1, 0, 0, RWE | PCJ | BSY, 5'd24);
        cyc("idle_clr_ignored", 0, 5'd0, 1, 0, 1, 10'b0, 5'd0);
        cyc("idle_stays",       0, 5'd0, 1, 0, 0, 10'b0, 5'd0);

        // Illegal dispatch 0, then 27
        cyc("ill0_idle",   1, 5'd0, 1, 0, 0, 10'b0, 5'd0);
        cyc("ill0_fetch",  1, 5'd0, 1, 0, 0, FT, 5'd0);
        cyc("ill0_decode", 1, 5'd0, 1, 0, 0, BSY, 5'd0);
        cyc("ill0_trap",   1, 5'd1, 1, 1, 0, TRP, 5'd0);
        cyc("ill0_trap",   1, 5'd1, 1, 1, 0, TRP, 5'd0);
        cyc("ill0_trapclr",1, 5'd1, 1, 1, 1, TRP, 5'd0);
        cyc("ill0_idle2",  0, 5'd27, 1, 0, 0, 10'b0, 5'd0);
        cyc("ill27_idle",  1, 5'd27, 1, 0, 0, 10'b0, 5'd0);
        cyc("ill27_fetch", 1, 5'd27, 1, 0, 0, FT, 5'd0);
        cyc("ill27_decode",1, 5'd27, 1, 0, 0, BSY, 5'd0);
        cyc("ill27_trap",  1, 5'd27, 1, 0, 0, TRP, 5'd0);
        cyc("ill27_clr",   0, 5'd27, 1, 0, 1, TRP, 5'd0);
        cyc("ill27_idle2", 0, 5'd27, 1, 0, 0, 10'b0, 5'd0);

        // Asynchronous reset in the middle of a MEM cycle
        cyc("rst_idle",   1, 5'd20, 1, 0, 0, 10'b0, 5'd0);
        cyc("rst_fetch",  1, 5'd20, 1, 0, 0, FT, 5'd0);
        cyc("rst_decode", 1, 5'd20, 1, 0, 0, BSY, 5'd0);
        cyc("rst_exec",   1, 5'd20, 1, 0, 0, BSY, 5'd20);
        bus.dmem_ready = 1'b0;
        push_exp(DREQ | BSY, 5'd20);
        #2;
        check("rst_mem");
        rst_n = 1'b0;
        push_exp(10'b0, 5'd0);
        #1;
        check("rst_async_zero");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rst_after_idle", 0, 5'd20, 1, 0, 0, 10'b0, 5'd0);
        cyc("rst_after_run",  1, 5'd20, 1, 0, 0, 10'b0, 5'd0);
        cyc("rst_after_fetch",1, 5'd20, 1, 0, 0, FT, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
